// File: rtl/drive_mode_fsm.sv
// Drive-mode controller: arbitrates IR remote, camera tracking and audio speed
// into one registered drive command, with manual dead-man and search timeouts.
module drive_mode_fsm #(
    parameter int DIR_W         = 3,
    parameter int SPEED_W       = 4,
    parameter int CMD_W         = 3,
    parameter int MANUAL_HOLD   = 25_000_000,
    parameter int LOST_CYCLES   = 12_500_000,
    parameter int SEARCH_CYCLES = 100_000_000,
    parameter int SEARCH_SPEED  = 4
) (
    input  logic               clk_50,
    input  logic               rst_n,
    input  logic [CMD_W-1:0]   ir_cmd,
    input  logic               ir_toggle,
    input  logic [DIR_W-1:0]   cam_dir,
    input  logic               cam_valid,
    input  logic [SPEED_W-1:0] speed_in,
    output logic [1:0]         state,
    output logic [2:0]         drive_cmd,
    output logic [SPEED_W-1:0] drive_speed,
    output logic               mode_change
);

    localparam int HOLD_W   = $clog2(MANUAL_HOLD + 1);
    localparam int LOST_W   = $clog2(LOST_CYCLES + 1);
    localparam int SEARCH_W = $clog2(SEARCH_CYCLES + 1);
    localparam int CENTRE   = DIR_W / 2;

    localparam logic [HOLD_W-1:0]   HOLD_LOAD   = HOLD_W'(MANUAL_HOLD);
    localparam logic [LOST_W-1:0]   LOST_LAST   = LOST_W'(LOST_CYCLES - 1);
    localparam logic [SEARCH_W-1:0] SEARCH_LAST = SEARCH_W'(SEARCH_CYCLES - 1);
    localparam logic [SPEED_W-1:0]  SRCH_SPD    = SPEED_W'(SEARCH_SPEED);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_TRACK  = 2'd2,
        ST_SEARCH = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        DRV_STOP  = 3'd0,
        DRV_FWD   = 3'd1,
        DRV_BACK  = 3'd2,
        DRV_LEFT  = 3'd3,
        DRV_RIGHT = 3'd4
    } drive_t;

    function automatic logic is_onehot(input logic [DIR_W-1:0] v);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < DIR_W; i++) begin
            if (v[i]) begin
                if (seen) multi = 1'b1;
                else      seen  = 1'b1;
            end
        end
        return seen & ~multi;
    endfunction

    // Caller guarantees v is one-hot; zones left of centre steer left.
    function automatic drive_t zone_cmd(input logic [DIR_W-1:0] v);
        int z;
        z = 0;
        for (int i = 0; i < DIR_W; i++) begin
            if (v[i]) z = i;
        end
        if (z < CENTRE)       return DRV_LEFT;
        else if (z == CENTRE) return DRV_FWD;
        else                  return DRV_RIGHT;
    endfunction

    state_t                state_r, state_s;
    drive_t                drive_cmd_r, drive_cmd_s;
    logic [SPEED_W-1:0]    drive_speed_r, drive_speed_s;
    logic                  mode_change_r;
    logic [HOLD_W-1:0]     hold_cnt_r, hold_cnt_s;
    logic [LOST_W-1:0]     lost_cnt_r, lost_cnt_s;
    logic [SEARCH_W-1:0]   search_cnt_r, search_cnt_s;
    logic                  armed_r;
    logic                  tog_r;
    logic                  ir_event_s;
    logic [2:0]            ir_code_s;
    logic                  target_s;
    logic                  motion_s;

    assign ir_event_s = armed_r & (ir_toggle ^ tog_r);
    assign target_s   = cam_valid & is_onehot(cam_dir);
    assign motion_s   = (ir_code_s >= 3'd1) && (ir_code_s <= 3'd4);

    // Decode IR command; codes beyond the defined set behave as NOP.
    always_comb begin
        ir_code_s = 3'd0;
        if (ir_cmd > CMD_W'(3'd7)) ir_code_s = 3'd0;
        else                       ir_code_s = ir_cmd[2:0];
    end

    // Toggle copy; the first cycle after reset only captures the toggle level.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            armed_r <= 1'b0;
            tog_r   <= 1'b0;
        end else begin
            armed_r <= 1'b1;
            tog_r   <= ir_toggle;
        end
    end

    // Next-state and next-output logic: IR events take priority over camera/timeouts.
    always_comb begin
        state_s       = state_r;
        drive_cmd_s   = drive_cmd_r;
        drive_speed_s = drive_speed_r;
        hold_cnt_s    = hold_cnt_r;
        lost_cnt_s    = lost_cnt_r;
        search_cnt_s  = search_cnt_r;
        if (ir_event_s && ir_code_s == 3'd5) begin
            state_s       = ST_IDLE;
            drive_cmd_s   = DRV_STOP;
            drive_speed_s = '0;
            hold_cnt_s    = '0;
            lost_cnt_s    = '0;
            search_cnt_s  = '0;
        end else if (ir_event_s && ir_code_s == 3'd6) begin
            state_s       = ST_TRACK;
            drive_cmd_s   = DRV_STOP;
            drive_speed_s = '0;
            hold_cnt_s    = '0;
            lost_cnt_s    = '0;
            search_cnt_s  = '0;
        end else if (ir_event_s && ir_code_s == 3'd7) begin
            state_s       = ST_MANUAL;
            drive_cmd_s   = DRV_STOP;
            drive_speed_s = '0;
            hold_cnt_s    = '0;
        end else if (ir_event_s && motion_s &&
                     (state_r == ST_IDLE || state_r == ST_MANUAL)) begin
            state_s       = ST_MANUAL;
            drive_cmd_s   = drive_t'(ir_code_s);
            drive_speed_s = speed_in;
            hold_cnt_s    = HOLD_LOAD;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    drive_cmd_s   = DRV_STOP;
                    drive_speed_s = '0;
                end
                ST_MANUAL: begin
                    if (drive_cmd_r != DRV_STOP) begin
                        // Dead-man: stop on the cycle the hold counter hits zero.
                        if (hold_cnt_r <= HOLD_W'(1'b1)) begin
                            hold_cnt_s    = '0;
                            drive_cmd_s   = DRV_STOP;
                            drive_speed_s = '0;
                        end else begin
                            hold_cnt_s    = hold_cnt_r - HOLD_W'(1'b1);
                            drive_speed_s = speed_in;
                        end
                    end else begin
                        drive_speed_s = '0;
                    end
                end
                ST_TRACK: begin
                    if (cam_valid) begin
                        lost_cnt_s = '0;
                        if (target_s) begin
                            drive_cmd_s   = zone_cmd(cam_dir);
                            drive_speed_s = speed_in;
                        end else begin
                            drive_cmd_s = drive_cmd_r;
                        end
                    end else if (lost_cnt_r >= LOST_LAST) begin
                        state_s       = ST_SEARCH;
                        drive_cmd_s   = DRV_RIGHT;
                        drive_speed_s = SRCH_SPD;
                        lost_cnt_s    = '0;
                        search_cnt_s  = '0;
                    end else begin
                        lost_cnt_s = lost_cnt_r + LOST_W'(1'b1);
                    end
                end
                ST_SEARCH: begin
                    if (target_s) begin
                        state_s       = ST_TRACK;
                        drive_cmd_s   = zone_cmd(cam_dir);
                        drive_speed_s = speed_in;
                        lost_cnt_s    = '0;
                        search_cnt_s  = '0;
                    end else if (search_cnt_r >= SEARCH_LAST) begin
                        state_s       = ST_IDLE;
                        drive_cmd_s   = DRV_STOP;
                        drive_speed_s = '0;
                        search_cnt_s  = '0;
                    end else begin
                        search_cnt_s  = search_cnt_r + SEARCH_W'(1'b1);
                        drive_cmd_s   = DRV_RIGHT;
                        drive_speed_s = SRCH_SPD;
                    end
                end
                default: begin
                    state_s       = ST_IDLE;
                    drive_cmd_s   = DRV_STOP;
                    drive_speed_s = '0;
                end
            endcase
        end
    end

    // State, outputs and counters register; mode_change flags any state change.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            drive_cmd_r   <= DRV_STOP;
            drive_speed_r <= '0;
            mode_change_r <= 1'b0;
            hold_cnt_r    <= '0;
            lost_cnt_r    <= '0;
            search_cnt_r  <= '0;
        end else begin
            state_r       <= state_s;
            drive_cmd_r   <= drive_cmd_s;
            drive_speed_r <= drive_speed_s;
            mode_change_r <= (state_s != state_r);
            hold_cnt_r    <= hold_cnt_s;
            lost_cnt_r    <= lost_cnt_s;
            search_cnt_r  <= search_cnt_s;
        end
    end

    assign state       = state_r;
    assign drive_cmd   = drive_cmd_r;
    assign drive_speed = drive_speed_r;
    assign mode_change = mode_change_r;

endmodule

// File: tb/tb_drive_mode_fsm.sv
// Directed self-checking bench for drive_mode_fsm with short timeouts.
module tb_drive_mode_fsm;

    logic       clk_50;
    logic       rst_n;
    logic [2:0] ir_cmd;
    logic       ir_toggle;
    logic [2:0] cam_dir;
    logic       cam_valid;
    logic [3:0] speed_in;
    logic [1:0] state;
    logic [2:0] drive_cmd;
    logic [3:0] drive_speed;
    logic       mode_change;

    int checks;
    int errors;

    drive_mode_fsm #(
        .DIR_W(3), .SPEED_W(4), .CMD_W(3),
        .MANUAL_HOLD(20), .LOST_CYCLES(8), .SEARCH_CYCLES(16), .SEARCH_SPEED(4)
    ) dut (
        .clk_50(clk_50), .rst_n(rst_n), .ir_cmd(ir_cmd), .ir_toggle(ir_toggle),
        .cam_dir(cam_dir), .cam_valid(cam_valid), .speed_in(speed_in),
        .state(state), .drive_cmd(drive_cmd), .drive_speed(drive_speed),
        .mode_change(mode_change)
    );

    initial clk_50 = 1'b0;
    always #5 clk_50 = ~clk_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    task automatic send_ir(input logic [2:0] code);
        ir_cmd    = code;
        ir_toggle = ~ir_toggle;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        ir_cmd    = 3'd0;
        ir_toggle = 1'b1;
        cam_dir   = 3'b000;
        cam_valid = 1'b0;
        speed_in  = 4'd0;
        tick(2);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_cmd", 32'(drive_cmd), 32'd0);
        chk("rst_speed", 32'(drive_speed), 32'd0);
        chk("rst_mc", 32'(mode_change), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("post_rst_state", 32'(state), 32'd0);
            chk("post_rst_cmd", 32'(drive_cmd), 32'd0);
            chk("post_rst_mc", 32'(mode_change), 32'd0);
        end

        // Manual FWD and dead-man timeout
        speed_in = 4'd9;
        send_ir(3'd1);
        tick(1);
        chk("man_state", 32'(state), 32'd1);
        chk("man_cmd", 32'(drive_cmd), 32'd1);
        chk("man_speed", 32'(drive_speed), 32'd9);
        chk("man_mc", 32'(mode_change), 32'd1);
        speed_in = 4'd5;
        tick(1);
        chk("man_track_speed", 32'(drive_speed), 32'd5);
        chk("man_mc_low", 32'(mode_change), 32'd0);
        tick(18);
        chk("man_before_to", 32'(drive_cmd), 32'd1);
        tick(1);
        chk("man_to_cmd", 32'(drive_cmd), 32'd0);
        chk("man_to_speed", 32'(drive_speed), 32'd0);
        chk("man_to_state", 32'(state), 32'd1);

        // AUTO and zone steering
        send_ir(3'd6);
        tick(1);
        chk("auto_state", 32'(state), 32'd2);
        chk("auto_mc", 32'(mode_change), 32'd1);
        cam_valid = 1'b1; cam_dir = 3'b001; speed_in = 4'd7;
        tick(1);
        chk("zone_left", 32'(drive_cmd), 32'd3);
        chk("zone_left_spd", 32'(drive_speed), 32'd7);
        cam_dir = 3'b010; speed_in = 4'd6;
        tick(1);
        chk("zone_fwd", 32'(drive_cmd), 32'd1);
        chk("zone_fwd_spd", 32'(drive_speed), 32'd6);
        cam_dir = 3'b100; speed_in = 4'd5;
        tick(1);
        chk("zone_right", 32'(drive_cmd), 32'd4);
        chk("zone_right_spd", 32'(drive_speed), 32'd5);
        cam_dir = 3'b110; speed_in = 4'd2;
        tick(1);
        chk("bad_dir_cmd", 32'(drive_cmd), 32'd4);
        chk("bad_dir_spd", 32'(drive_speed), 32'd5);
        cam_dir = 3'b100;
        send_ir(3'd6);
        tick(1);
        chk("auto_again_state", 32'(state), 32'd2);
        chk("auto_again_mc", 32'(mode_change), 32'd0);
        speed_in = 4'd3;
        tick(1);
        chk("retrack_cmd", 32'(drive_cmd), 32'd4);
        chk("retrack_spd", 32'(drive_speed), 32'd3);

        // Target loss -> SEARCH -> timeout to IDLE
        cam_valid = 1'b0;
        tick(7);
        chk("lost_still_track", 32'(state), 32'd2);
        chk("lost_hold_spd", 32'(drive_speed), 32'd3);
        tick(1);
        chk("search_state", 32'(state), 32'd3);
        chk("search_cmd", 32'(drive_cmd), 32'd4);
        chk("search_spd", 32'(drive_speed), 32'd4);
        chk("search_mc", 32'(mode_change), 32'd1);
        tick(15);
        chk("search_still", 32'(state), 32'd3);
        tick(1);
        chk("search_to_state", 32'(state), 32'd0);
        chk("search_to_cmd", 32'(drive_cmd), 32'd0);
        chk("search_to_spd", 32'(drive_speed), 32'd0);
        chk("search_to_mc", 32'(mode_change), 32'd1);

        // SEARCH reacquires target; motion command ignored while searching
        send_ir(3'd6);
        tick(1);
        chk("auto2_state", 32'(state), 32'd2);
        tick(8);
        chk("search2_state", 32'(state), 32'd3);
        send_ir(3'd1);
        tick(1);
        chk("search_ign_state", 32'(state), 32'd3);
        chk("search_ign_cmd", 32'(drive_cmd), 32'd4);
        chk("search_ign_spd", 32'(drive_speed), 32'd4);
        tick(3);
        cam_valid = 1'b1; cam_dir = 3'b001; speed_in = 4'd8;
        tick(1);
        chk("reacq_state", 32'(state), 32'd2);
        chk("reacq_cmd", 32'(drive_cmd), 32'd3);
        chk("reacq_spd", 32'(drive_speed), 32'd8);
        chk("reacq_mc", 32'(mode_change), 32'd1);

        // IR STOP beats camera in the same cycle
        cam_dir = 3'b010;
        send_ir(3'd5);
        tick(1);
        chk("stop_pri_state", 32'(state), 32'd0);
        chk("stop_pri_cmd", 32'(drive_cmd), 32'd0);
        chk("stop_pri_spd", 32'(drive_speed), 32'd0);
        chk("stop_pri_mc", 32'(mode_change), 32'd1);
        cam_valid = 1'b0;

        // Asynchronous reset while moving
        speed_in = 4'd9;
        send_ir(3'd1);
        tick(1);
        chk("pre_arst_cmd", 32'(drive_cmd), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_cmd", 32'(drive_cmd), 32'd0);
        chk("arst_spd", 32'(drive_speed), 32'd0);
        chk("arst_mc", 32'(mode_change), 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        chk("arst_rel_state", 32'(state), 32'd0);
        chk("arst_rel_cmd", 32'(drive_cmd), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
